// File: rtl/spi_flash_responder_if.sv
// Bus bundle between an SPI flash initiator plus a byte-wide read memory and the responder.
// The slave modport is the responder's view; master is the environment driving it.
interface spi_flash_responder_if;
  logic        flash_csn;
  logic        flash_sck;
  logic        flash_mosi;
  logic        flash_miso;
  logic [23:0] mem_addr;
  logic        mem_req;
  logic [7:0]  mem_rdata;
  logic        busy;
  logic        cmd_error;

  modport slave (
    input  flash_csn, flash_sck, flash_mosi, mem_rdata,
    output flash_miso, mem_addr, mem_req, busy, cmd_error
  );

  modport master (
    output flash_csn, flash_sck, flash_mosi, mem_rdata,
    input  flash_miso, mem_addr, mem_req, busy, cmd_error
  );
endinterface

// File: rtl/spi_flash_responder.sv
// SPI mode-0 flash read responder: decodes 0x03/0x0B reads, streams bytes from a
// 1-cycle-latency memory with a one-byte prefetch, oversampling sck on the system clock.
module spi_flash_responder #(
  parameter int unsigned SCK_MIN_RATIO = 8
) (
  input logic                  clk,
  input logic                  reset,
  spi_flash_responder_if.slave bus
);

  // Two sync stages plus one edge-detect stage need half sck phases of at least 4 clk.
  if (SCK_MIN_RATIO < 8) begin : g_ratio_check
    $error("SCK_MIN_RATIO must be at least 8");
  end

  typedef enum logic [2:0] {StIdle, StCmd, StAddr, StDummy, StData, StIgnore} state_e;

  // Sync vectors: [0] first stage, [1] synchronized value, [2] delayed copy for edges.
  logic [2:0]  csn_sync_q, csn_sync_d;
  logic [2:0]  sck_sync_q, sck_sync_d;
  logic [1:0]  mosi_sync_q, mosi_sync_d;
  state_e      state_q, state_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [22:0] rx_sr_q, rx_sr_d;
  logic [6:0]  tx_sr_q, tx_sr_d;
  logic [7:0]  prefetch_q, prefetch_d;
  logic        rd_pend_q, rd_pend_d;
  logic        fast_q, fast_d;
  logic [23:0] mem_addr_q, mem_addr_d;
  logic        mem_req_q, mem_req_d;
  logic        cmd_error_q, cmd_error_d;
  logic        miso_q, miso_d;

  logic       csn_high, csn_fall, sck_rise, sck_fall, mosi_s;
  logic [7:0] opcode;

  assign csn_high = csn_sync_q[1];
  assign csn_fall = csn_sync_q[2] & ~csn_sync_q[1];
  assign sck_rise = sck_sync_q[1] & ~sck_sync_q[2];
  assign sck_fall = ~sck_sync_q[1] & sck_sync_q[2];
  assign mosi_s   = mosi_sync_q[1];
  assign opcode   = {rx_sr_q[6:0], mosi_s};

  always_comb begin
    csn_sync_d  = {csn_sync_q[1:0], bus.flash_csn};
    sck_sync_d  = {sck_sync_q[1:0], bus.flash_sck};
    mosi_sync_d = {mosi_sync_q[0], bus.flash_mosi};
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_sr_d     = rx_sr_q;
    tx_sr_d     = tx_sr_q;
    fast_d      = fast_q;
    mem_addr_d  = mem_addr_q;
    mem_req_d   = 1'b0;
    cmd_error_d = 1'b0;
    miso_d      = miso_q;
    rd_pend_d   = mem_req_q;
    prefetch_d  = rd_pend_q ? bus.mem_rdata : prefetch_q;

    // csn high overrides everything, including an sck edge seen in the same cycle.
    if (csn_high) begin
      state_d   = StIdle;
      bit_cnt_d = '0;
      miso_d    = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          miso_d = 1'b1;
          if (csn_fall) begin
            state_d   = StCmd;
            bit_cnt_d = '0;
            rx_sr_d   = '0;
          end
        end
        StCmd: begin
          miso_d = 1'b1;
          if (sck_rise) begin
            rx_sr_d   = {rx_sr_q[21:0], mosi_s};
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd7) begin
              bit_cnt_d = '0;
              rx_sr_d   = '0;
              case (opcode)
                8'h03: begin
                  state_d = StAddr;
                  fast_d  = 1'b0;
                end
                8'h0B: begin
                  state_d = StAddr;
                  fast_d  = 1'b1;
                end
                8'hAB: state_d = StIgnore;
                default: begin
                  state_d     = StIgnore;
                  cmd_error_d = 1'b1;
                end
              endcase
            end
          end
        end
        StAddr: begin
          miso_d = 1'b1;
          if (sck_rise) begin
            rx_sr_d   = {rx_sr_q[21:0], mosi_s};
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd23) begin
              mem_addr_d = {rx_sr_q, mosi_s};
              mem_req_d  = 1'b1;
              bit_cnt_d  = '0;
              state_d    = fast_q ? StDummy : StData;
            end
          end
        end
        StDummy: begin
          miso_d = 1'b1;
          if (sck_rise) begin
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd7) begin
              bit_cnt_d = '0;
              state_d   = StData;
            end
          end
        end
        StData: begin
          if (sck_fall) begin
            if (bit_cnt_q == 5'd0) begin
              // Byte boundary: emit the prefetched byte and fetch the following one.
              tx_sr_d    = prefetch_q[6:0];
              miso_d     = prefetch_q[7];
              mem_addr_d = mem_addr_q + 24'd1;
              mem_req_d  = 1'b1;
              bit_cnt_d  = 5'd1;
            end else begin
              tx_sr_d   = {tx_sr_q[5:0], 1'b0};
              miso_d    = tx_sr_q[6];
              bit_cnt_d = (bit_cnt_q == 5'd7) ? 5'd0 : bit_cnt_q + 5'd1;
            end
          end
        end
        StIgnore: miso_d = 1'b1;
        default: begin
          state_d = StIdle;
          miso_d  = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      csn_sync_q  <= '0;
      sck_sync_q  <= '0;
      mosi_sync_q <= '0;
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      rx_sr_q     <= '0;
      tx_sr_q     <= '0;
      prefetch_q  <= '0;
      rd_pend_q   <= 1'b0;
      fast_q      <= 1'b0;
      mem_addr_q  <= '0;
      mem_req_q   <= 1'b0;
      cmd_error_q <= 1'b0;
      miso_q      <= 1'b1;
    end else begin
      csn_sync_q  <= csn_sync_d;
      sck_sync_q  <= sck_sync_d;
      mosi_sync_q <= mosi_sync_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_sr_q     <= rx_sr_d;
      tx_sr_q     <= tx_sr_d;
      prefetch_q  <= prefetch_d;
      rd_pend_q   <= rd_pend_d;
      fast_q      <= fast_d;
      mem_addr_q  <= mem_addr_d;
      mem_req_q   <= mem_req_d;
      cmd_error_q <= cmd_error_d;
      miso_q      <= miso_d;
    end
  end

  assign bus.flash_miso = miso_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_req    = mem_req_q;
  assign bus.cmd_error  = cmd_error_q;
  assign bus.busy       = (state_q != StIdle);

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench: table of SPI transactions against a mem[n] = n[7:0] model, plus
// hand-written abort and mid-transfer reset sequences.
module tb_spi_flash_responder;

  localparam int unsigned Half = 4;  // sck half period in clk cycles (minimum tolerated)
  localparam int          NumVec = 6;

  typedef struct {
    logic [7:0]      op;
    logic [23:0]     addr;
    int              nbytes;
    logic [3:0][7:0] exp;
    int              exp_req;
    int              exp_err;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  spi_flash_responder_if bus ();

  spi_flash_responder #(.SCK_MIN_RATIO(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Memory: data valid exactly one cycle after mem_req, junk otherwise.
  always @(posedge clk) bus.mem_rdata <= bus.mem_req ? bus.mem_addr[7:0] : 8'h5A;

  int          n_checks = 0;
  int          n_fail = 0;
  int          req_cnt, err_cnt, miso_low_cnt;
  logic [23:0] first_addr;
  logic        miso_chk = 1'b0;

  always @(negedge clk) begin
    if (bus.mem_req) begin
      req_cnt = req_cnt + 1;
      if (req_cnt == 1) first_addr = bus.mem_addr;
    end
    if (bus.cmd_error) err_cnt = err_cnt + 1;
    if (miso_chk && !bus.flash_miso) miso_low_cnt = miso_low_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_counts();
    req_cnt      = 0;
    err_cnt      = 0;
    miso_low_cnt = 0;
    first_addr   = '1;
  endtask

  task automatic half();
    repeat (Half) @(posedge clk);
    #1;
  endtask

  // Mode 0: sck falls at the start of each bit, miso sampled just before the rise.
  task automatic xfer_bit(input logic mo, output logic mi);
    bus.flash_sck  = 1'b0;
    bus.flash_mosi = mo;
    half();
    mi = bus.flash_miso;
    bus.flash_sck = 1'b1;
    half();
  endtask

  task automatic xfer_byte(input logic [7:0] o, output logic [7:0] i);
    logic [7:0] r;
    logic       b;
    for (int k = 7; k >= 0; k--) begin
      xfer_bit(o[k], b);
      r[k] = b;
    end
    i = r;
  endtask

  // sck and csn released together; csn must win so no extra byte load occurs.
  task automatic end_txn();
    bus.flash_sck = 1'b0;
    bus.flash_csn = 1'b1;
    miso_chk      = 1'b0;
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic run_txn(input logic [7:0] op, input logic [23:0] addr, input int nbytes,
                         output logic [3:0][7:0] got, output logic [7:0] pre_miso);
    logic [7:0] b;
    logic [7:0] acc;
    clear_counts();
    got           = '0;
    miso_chk      = 1'b1;
    bus.flash_csn = 1'b0;
    half();
    xfer_byte(op, b);
    acc = b;
    if (op == 8'h03 || op == 8'h0B) begin
      xfer_byte(addr[23:16], b);
      acc = acc & b;
      xfer_byte(addr[15:8], b);
      acc = acc & b;
      xfer_byte(addr[7:0], b);
      acc = acc & b;
      if (op == 8'h0B) begin
        xfer_byte(8'hC3, b);
        acc = acc & b;
      end
      miso_chk = 1'b0;
    end
    pre_miso = acc;
    for (int i = 0; i < nbytes; i++) begin
      xfer_byte(8'h00, b);
      got[i] = b;
    end
    end_txn();
  endtask

  vec_t            vecs [NumVec];
  logic [3:0][7:0] got;
  logic [7:0]      pre;
  logic [7:0]      junk;
  logic            bit_junk;

  initial begin
    vecs[0] = '{8'h03, 24'h000100, 3, 32'h0002_0100, 4, 0};
    vecs[1] = '{8'h0B, 24'h000010, 1, 32'h0000_0010, 2, 0};
    vecs[2] = '{8'h03, 24'hFFFFFF, 2, 32'h0000_00FF, 3, 0};
    vecs[3] = '{8'h9F, 24'h000000, 2, 32'h0000_FFFF, 0, 1};
    vecs[4] = '{8'hAB, 24'h000000, 2, 32'h0000_FFFF, 0, 0};
    vecs[5] = '{8'h03, 24'h123456, 2, 32'h0000_5756, 3, 0};

    reset          = 1'b1;
    bus.flash_csn  = 1'b1;
    bus.flash_sck  = 1'b0;
    bus.flash_mosi = 1'b0;
    clear_counts();
    repeat (4) @(posedge clk);
    #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_miso", 32'(bus.flash_miso), 32'd1);
    check("rst_req", 32'(bus.mem_req), 32'd0);
    check("rst_err", 32'(bus.cmd_error), 32'd0);
    check("rst_addr", 32'(bus.mem_addr), 32'd0);
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    for (int v = 0; v < NumVec; v++) begin
      run_txn(vecs[v].op, vecs[v].addr, vecs[v].nbytes, got, pre);
      for (int i = 0; i < vecs[v].nbytes; i++)
        check($sformatf("v%0d_byte%0d", v, i), 32'(got[i]), 32'(vecs[v].exp[i]));
      check($sformatf("v%0d_hdr_miso", v), 32'(pre), 32'hFF);
      check($sformatf("v%0d_req_cnt", v), 32'(req_cnt), 32'(vecs[v].exp_req));
      check($sformatf("v%0d_err_cnt", v), 32'(err_cnt), 32'(vecs[v].exp_err));
      check($sformatf("v%0d_miso_low", v), 32'(miso_low_cnt), 32'd0);
      check($sformatf("v%0d_busy_end", v), 32'(bus.busy), 32'd0);
      if (vecs[v].exp_req > 0)
        check($sformatf("v%0d_first_addr", v), 32'(first_addr), 32'(vecs[v].addr));
    end

    // Abort after 12 address bits.
    clear_counts();
    bus.flash_csn = 1'b0;
    half();
    xfer_byte(8'h03, junk);
    for (int k = 0; k < 12; k++) xfer_bit(1'b0, bit_junk);
    bus.flash_sck = 1'b0;
    bus.flash_csn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("abort_busy_3clk", 32'(bus.busy), 32'd0);
    check("abort_miso", 32'(bus.flash_miso), 32'd1);
    check("abort_req", 32'(req_cnt), 32'd0);
    check("abort_err", 32'(err_cnt), 32'd0);
    run_txn(8'h03, 24'h000042, 1, got, pre);
    check("after_abort_byte", 32'(got[0]), 32'h42);
    check("after_abort_req", 32'(req_cnt), 32'd2);

    // Reset in the middle of a data byte with csn held low.
    clear_counts();
    bus.flash_csn = 1'b0;
    half();
    xfer_byte(8'h03, junk);
    xfer_byte(8'h00, junk);
    xfer_byte(8'h00, junk);
    xfer_byte(8'h80, junk);
    xfer_byte(8'h00, junk);
    check("mid_first_byte", 32'(junk), 32'h80);
    for (int k = 0; k < 3; k++) xfer_bit(1'b0, bit_junk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_miso", 32'(bus.flash_miso), 32'd1);
    check("midrst_req", 32'(bus.mem_req), 32'd0);
    check("midrst_addr", 32'(bus.mem_addr), 32'd0);
    check("midrst_err", 32'(bus.cmd_error), 32'd0);
    reset = 1'b0;
    clear_counts();
    miso_chk = 1'b1;
    for (int k = 0; k < 16; k++) xfer_bit(1'b0, bit_junk);
    check("postrst_req", 32'(req_cnt), 32'd0);
    check("postrst_busy", 32'(bus.busy), 32'd0);
    check("postrst_miso_low", 32'(miso_low_cnt), 32'd0);
    end_txn();
    run_txn(8'h03, 24'h000080, 1, got, pre);
    check("postrst_read_byte", 32'(got[0]), 32'h80);
    check("postrst_read_req", 32'(req_cnt), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
